// File: rtl/mixer_pkg.sv
// Shared definitions for the multi-voice mixer: FSM encoding, mix-mode constants
// and the accumulator guard width.
package mixer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_SUM     = 3'd2,
        ST_SCALE   = 3'd3,
        ST_DONE    = 3'd4
    } mixer_state_t;

    localparam logic MODE_SUM = 1'b0;
    localparam logic MODE_AVG = 1'b1;

    // Enough headroom to add up to 8 full-scale voices without wrapping.
    localparam int ACC_GUARD_W = 3;

endpackage

// File: rtl/sat_clip.sv
// Signed saturating narrower: clips an IN_W-bit two's-complement value into the
// OUT_W-bit range, or sign-extends when the output is not narrower.
module sat_clip #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 18
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    generate
        if (IN_W > OUT_W) begin : g_clip
            // In range exactly when the dropped bits all match the result sign bit.
            always_comb begin
                if ((&din[IN_W-1:OUT_W-1]) || !(|din[IN_W-1:OUT_W-1])) begin
                    dout = din[OUT_W-1:0];
                end else if (din[IN_W-1]) begin
                    dout = {1'b1, {(OUT_W-1){1'b0}}};
                end else begin
                    dout = {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
        end else begin : g_ext
            assign dout = OUT_W'(din);
        end
    endgenerate

endmodule

// File: rtl/multi_voice_mixer.sv
// Request-driven mixer: collects one sample per active voice, sums them serially
// into a guarded accumulator, then saturates (sum) or shifts and saturates (average).
module multi_voice_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_W   = 18,
    parameter int TIMEOUT    = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           generate_next_sample,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]          voice_ready,
    input  logic [NUM_VOICES-1:0]          voice_active,
    input  logic                           avg_mode,
    output logic [SAMPLE_W-1:0]            mixed_sample,
    output logic                           mixed_ready,
    output logic                           missed_voice,
    output logic                           overrun
);

    localparam int ACC_W = SAMPLE_W + ACC_GUARD_W;
    localparam int SHIFT = $clog2(NUM_VOICES);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    mixer_state_t state_reg, state_next;

    logic [NUM_VOICES-1:0]    active_snap_reg;
    logic [NUM_VOICES-1:0]    captured_reg;
    logic [NUM_VOICES-1:0]    captured_next;
    logic [NUM_VOICES-1:0]    capture_hit;
    logic                     mode_reg;
    logic [SAMPLE_W-1:0]      voice_reg [NUM_VOICES];
    logic [TO_W-1:0]          timeout_cnt_reg;
    logic [IDX_W-1:0]         sum_idx_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [ACC_W-1:0]  addend;
    logic signed [SAMPLE_W-1:0] clip_out;
    logic [SAMPLE_W-1:0]      mixed_sample_reg;
    logic                     mixed_ready_reg;
    logic                     missed_voice_reg;
    logic                     overrun_reg;

    logic collect_done;
    logic timeout_hit;
    logic sum_last;

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_capture
            assign capture_hit[gi] = (state_reg == ST_COLLECT) && voice_ready[gi]
                                     && active_snap_reg[gi];
        end
    endgenerate

    assign captured_next = captured_reg | capture_hit;
    assign collect_done  = (captured_reg == active_snap_reg);
    assign timeout_hit   = (timeout_cnt_reg == TO_W'(TIMEOUT - 1));
    assign sum_last      = (sum_idx_reg == IDX_W'(NUM_VOICES - 1));

    // Voices that never arrived contribute zero rather than a stale sample.
    assign addend = captured_reg[sum_idx_reg] ? ACC_W'($signed(voice_reg[sum_idx_reg]))
                                              : '0;
    assign scaled = (mode_reg == MODE_AVG) ? (acc_reg >>> SHIFT) : acc_reg;

    sat_clip #(
        .IN_W  (ACC_W),
        .OUT_W (SAMPLE_W)
    ) u_sat_clip (
        .din  (scaled),
        .dout (clip_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (generate_next_sample) state_next = ST_COLLECT;
            ST_COLLECT: if (collect_done || timeout_hit) state_next = ST_SUM;
            ST_SUM:     if (sum_last) state_next = ST_SCALE;
            ST_SCALE:   state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_snap_reg  <= '0;
            captured_reg     <= '0;
            mode_reg         <= MODE_SUM;
            timeout_cnt_reg  <= '0;
            sum_idx_reg      <= '0;
            acc_reg          <= '0;
            mixed_sample_reg <= '0;
            mixed_ready_reg  <= 1'b0;
            missed_voice_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice_reg[i] <= '0;
            end
        end else begin
            mixed_ready_reg <= 1'b0;
            if (generate_next_sample && (state_reg != ST_IDLE)) begin
                overrun_reg <= 1'b1;
            end
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (capture_hit[i]) begin
                    voice_reg[i] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
                end
            end
            case (state_reg)
                ST_IDLE: begin
                    if (generate_next_sample) begin
                        active_snap_reg <= voice_active;
                        mode_reg        <= avg_mode;
                        captured_reg    <= '0;
                        timeout_cnt_reg <= '0;
                        sum_idx_reg     <= '0;
                        acc_reg         <= '0;
                    end
                end
                ST_COLLECT: begin
                    captured_reg <= captured_next;
                    if (!timeout_hit) begin
                        timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
                    end else if (!collect_done && (captured_next != active_snap_reg)) begin
                        missed_voice_reg <= 1'b1;
                    end
                end
                ST_SUM: begin
                    acc_reg     <= acc_reg + addend;
                    sum_idx_reg <= sum_idx_reg + IDX_W'(1);
                end
                ST_SCALE: begin
                    mixed_sample_reg <= clip_out;
                    mixed_ready_reg  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mixed_sample = mixed_sample_reg;
    assign mixed_ready  = mixed_ready_reg;
    assign missed_voice = missed_voice_reg;
    assign overrun      = overrun_reg;

endmodule

// File: doc/multi_voice_mixer.md
MULTI_VOICE_MIXER -- requirements
Module: multi_voice_mixer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3: number of voice inputs, legal range 1..8.
REQ-002 SHALL have parameter SAMPLE_W, default 18: signed two's-complement sample width.
REQ-003 SHALL have parameter TIMEOUT, default 64: number of COLLECT cycles allowed before forcing a mix.
REQ-004 SHALL have port clk, input, 1: system clock; the block uses one clock only.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port generate_next_sample, input, 1: one-cycle request for the next mixed sample.
REQ-007 SHALL have port voice_sample, input, NUM_VOICES*SAMPLE_W: voice i occupies bits [i*SAMPLE_W +: SAMPLE_W].
REQ-008 SHALL have port voice_ready, input, NUM_VOICES: per-voice one-cycle sample-valid pulse.
REQ-009 SHALL have port voice_active, input, NUM_VOICES: voices participating in the mix.
REQ-010 SHALL have port avg_mode, input, 1: 0 = saturating sum, 1 = average.
REQ-011 SHALL have port mixed_sample, output, SAMPLE_W: registered mix result.
REQ-012 SHALL have port mixed_ready, output, 1: one-cycle pulse when mixed_sample updates.
REQ-013 SHALL have port missed_voice, output, 1: sticky flag; a timeout occurred.
REQ-014 SHALL have port overrun, output, 1: sticky flag; a request arrived while the block was busy.

Function
REQ-015 SHALL implement the states IDLE, COLLECT, SUM, SCALE and DONE.
REQ-016 In IDLE, generate_next_sample SHALL snapshot voice_active and avg_mode, clear the capture mask and timeout counter, and enter COLLECT on the next cycle.
REQ-017 In COLLECT, each cycle SHALL latch voice i and set captured[i] when voice_ready[i] and active_snap[i] are both high; ready pulses arriving in IDLE SHALL be ignored.
REQ-018 COLLECT SHALL exit to SUM in the cycle after captured equals active_snap; an all-zero active_snap SHALL go to SUM after one COLLECT cycle.
REQ-019 If TIMEOUT cycles elapse in COLLECT, the block SHALL treat uncaptured voices as 0, set missed_voice, and enter SUM.
REQ-020 SUM SHALL take exactly NUM_VOICES cycles, adding one voice per cycle (index 0 first), sign-extended, into an accumulator of width SAMPLE_W+3.
REQ-021 In SCALE (1 cycle), avg_mode=0 SHALL clip the accumulator to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
REQ-022 In SCALE, avg_mode=1 SHALL arithmetic-shift the accumulator right by ceil(log2(NUM_VOICES)), with no rounding, then clip.
REQ-023 In DONE (1 cycle), the block SHALL assert mixed_ready, and mixed_sample SHALL hold the new value from that cycle until the next DONE; the next state is IDLE.
REQ-024 Latency: mixed_ready SHALL assert exactly NUM_VOICES+2 cycles after the COLLECT-exit cycle.
REQ-025 generate_next_sample outside IDLE SHALL be dropped and SHALL set overrun; a request coincident with the DONE cycle also counts as overrun.
REQ-026 A voice_ready for a voice already captured SHALL overwrite the stored sample while still in COLLECT.
REQ-027 voice_ready for inactive voices SHALL be ignored.

Reset
REQ-028 reset SHALL return the block to IDLE and clear mixed_sample to 0, mixed_ready, missed_voice, overrun, the capture mask, the accumulator and the counters, from any state.
REQ-029 A reset asserted mid-operation SHALL produce no mixed_ready pulse for the aborted request.

Structure
REQ-030 State encodings, the AVG/SUM mode constants and the accumulator guard width (3) SHALL live in shared package mixer_pkg.
REQ-031 Clipping SHALL be a sub-module sat_clip, parameterised by input width and output width.
REQ-032 Sticky flags SHALL clear only on reset.

Verification (NUM_VOICES=3, SAMPLE_W=18, TIMEOUT=16)
REQ-033 Active=111, mode 0, samples 1000/2000/-500 all ready in the cycle after the request -> mixed_sample=2500 and one mixed_ready pulse 5 cycles after COLLECT exit.
REQ-034 Samples 100000 x3, mode 0 -> 131071; samples -100000 x3 -> -131072.
REQ-035 Mode 1, samples 3000 x3 -> 2250 (9000>>2); samples -3 x3 -> -3 (-9>>2).
REQ-036 Active=111, voice 2 never ready, samples 400/600 -> after 16 COLLECT cycles mixed_sample=1000 and missed_voice=1.
REQ-037 Request pulsed during SUM -> no second mixed_ready and overrun=1; reset asserted during SUM -> outputs 0, no pulse, IDLE.
REQ-038 Active=000 -> mixed_sample=0 with mixed_ready, and missed_voice stays 0.
